// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the instruction-cycle controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  localparam int CW_W   = 33;
  localparam int STEP_W = 2;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Control-word field bit positions (LSB = 0)
  localparam int CW_NEXT_LO   = 0;
  localparam int CW_NEXT_HI   = 1;
  localparam int CW_STATUS_LD = 2;
  localparam int CW_PC_FS_LO  = 4;
  localparam int CW_PC_FS_HI  = 5;
  localparam int CW_PC_EN     = 6;
  localparam int CW_RAM_W     = 7;
  localparam int CW_RF_W      = 9;

  // PC function select for PC+4
  localparam logic [1:0] PC_INC = 2'b01;

  // Strip every architectural side effect from a word (register, RAM,
  // flag and PC writes) while leaving read/select fields intact.
  function automatic logic [CW_W-1:0] cw_no_writes(input logic [CW_W-1:0] cw);
    logic [CW_W-1:0] w_cw;
    w_cw                           = cw;
    w_cw[CW_RF_W]                  = 1'b0;
    w_cw[CW_RAM_W]                 = 1'b0;
    w_cw[CW_PC_EN]                 = 1'b0;
    w_cw[CW_PC_FS_HI:CW_PC_FS_LO]  = 2'b00;
    w_cw[CW_STATUS_LD]             = 1'b0;
    return w_cw;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bus bundle between the sequencer and the fetch/decode/datapath side.
// Latency: n/a (wires only).
// Backpressure: stall from the datapath freezes the sequencer.
interface control_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic [31:0]       instr_in;
  logic              instr_valid;
  logic              fetch_req;
  logic [31:0]       ir;
  logic [STEP_W-1:0] step;
  logic [CW_W-1:0]   cw_in;
  logic [CW_W-1:0]   cw_out;
  logic              stall;
  logic [4:0]        status_in;
  logic [4:0]        status;
  logic              halted;

  // Sequencer side
  modport master (
    input  instr_in, instr_valid, cw_in, stall, status_in,
    output fetch_req, ir, step, cw_out, status, halted
  );

  // Memory / decoder / datapath side
  modport slave (
    output instr_in, instr_valid, cw_in, stall, status_in,
    input  fetch_req, ir, step, cw_out, status, halted
  );

endinterface

// File: rtl/control_sequencer_cw_gate.sv
// Masks the decoder control word according to sequencer state, stall and reset.
// Latency: combinational.
// Backpressure: stall suppresses all write/PC side effects but keeps read selects.
module cw_gate
  import cpu_ctrl_pkg::*;
(
  input  state_t          i_state,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_instr_valid,
  input  logic [CW_W-1:0] i_cw,
  output logic [CW_W-1:0] o_cw
);

  // Select what the datapath sees this cycle
  always_comb begin
    o_cw = '0;
    if (!i_reset) begin
      case (i_state)
        FETCH: begin
          // Only the accept cycle advances the PC; a stalled fetch does nothing.
          if (i_instr_valid && !i_stall) begin
            o_cw[CW_PC_FS_HI:CW_PC_FS_LO] = PC_INC;
          end
        end
        EXEC: begin
          o_cw = i_stall ? cw_no_writes(i_cw) : i_cw;
        end
        default: o_cw = '0;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction-cycle controller: fetch into IR, step through control words, halt.
// Latency: fetch accept -> EXEC next cycle; one EXEC cycle per step.
// Backpressure: stall holds step/IR/status and blocks fetch accept.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input logic          clock,
  input logic          reset,
  control_sequencer_if.master bus
);

  state_t            r_state;
  logic [31:0]       r_ir;
  logic [STEP_W-1:0] r_step;
  logic [4:0]        r_status;
  logic              r_halted;
  logic [1:0]        r_loop_cnt;

  logic              w_accept;
  logic [STEP_W-1:0] w_next;
  logic              w_self;

  assign w_accept = (r_state == FETCH) && bus.instr_valid && !bus.stall;
  assign w_next   = bus.cw_in[CW_NEXT_HI:CW_NEXT_LO];
  // A word that names its own (nonzero) step as successor
  assign w_self   = (w_next != '0) && (w_next == r_step);

  // Sequencer FSM with IR, step, flags and the self-loop guard counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= FETCH;
      r_ir       <= '0;
      r_step     <= '0;
      r_status   <= '0;
      r_halted   <= 1'b0;
      r_loop_cnt <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          r_loop_cnt <= '0;
          if (w_accept) begin
            r_ir   <= bus.instr_in;
            r_step <= '0;
            // An all-zero instruction word is the halt encoding.
            if (bus.instr_in == 32'h0) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (!bus.stall) begin
            if (bus.cw_in[CW_STATUS_LD]) begin
              r_status <= bus.status_in;
            end
            if (w_next == '0) begin
              r_state <= FETCH;
            end else if (w_self && (r_loop_cnt == 2'd3)) begin
              // Fourth consecutive self-loop: the microcode is stuck.
              r_state  <= HALT;
              r_halted <= 1'b1;
            end else begin
              r_step     <= w_next;
              r_loop_cnt <= w_self ? r_loop_cnt + 2'd1 : 2'd0;
            end
          end
        end
        HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  cw_gate u_cw_gate (
    .i_state       (r_state),
    .i_reset       (reset),
    .i_stall       (bus.stall),
    .i_instr_valid (bus.instr_valid),
    .i_cw          (bus.cw_in),
    .o_cw          (bus.cw_out)
  );

  assign bus.fetch_req = !reset && (r_state == FETCH);
  assign bus.ir        = r_ir;
  assign bus.step      = r_step;
  assign bus.status    = r_status;
  assign bus.halted    = r_halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a per-cycle expectation scoreboard.
// Latency: stimulus pushes expectations after each edge; monitor checks at negedge.
// Backpressure: exercises stall in FETCH and EXEC.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  typedef struct packed {
    logic        fetch;
    logic [31:0] ir;
    logic [1:0]  step;
    logic [32:0] cw;
    logic [4:0]  status;
    logic        halted;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  control_sequencer_if bus();

  control_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t  q_exp[$];
  string q_nm[$];
  int    n_checks = 0;
  int    n_errors = 0;

  localparam logic [31:0] I1 = 32'h8B020020;
  localparam logic [31:0] I2 = 32'h12345678;
  localparam logic [31:0] I3 = 32'hAAAA0001;
  localparam logic [31:0] I4 = 32'h55550003;
  localparam logic [32:0] PCINC = 33'h0_0000_0010;

  function automatic exp_t mk(input logic f, input logic [31:0] ir, input logic [1:0] st,
                              input logic [32:0] cw, input logic [4:0] sts, input logic h);
    exp_t e;
    e.fetch = f; e.ir = ir; e.step = st; e.cw = cw; e.status = sts; e.halted = h;
    return e;
  endfunction

  // Push the expectation for the current cycle, then advance to just after the next edge.
  task automatic cyc(input string nm, input logic chk, input exp_t e);
    if (chk) begin
      q_exp.push_back(e);
      q_nm.push_back(nm);
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation
  always @(negedge clock) begin
    if (q_exp.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = q_exp.pop_front();
      nm = q_nm.pop_front();
      a  = mk(bus.fetch_req, bus.ir, bus.step, bus.cw_out, bus.status, bus.halted);
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL %s: got fetch=%b ir=%h step=%0d cw=%h status=%b halted=%b, want fetch=%b ir=%h step=%0d cw=%h status=%b halted=%b",
                 nm, a.fetch, a.ir, a.step, a.cw, a.status, a.halted,
                 e.fetch, e.ir, e.step, e.cw, e.status, e.halted);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_in    = '0;
    bus.stall       = 1'b0;
    bus.cw_in       = '0;
    bus.status_in   = '0;
    cyc("", 1'b0, '0);
    cyc("rst_hold", 1'b1, mk(0, 0, 0, 0, 0, 0));

    // Idle fetch, then a single-step instruction loading flags
    reset = 1'b0; bus.cw_in = 33'h1_0000_0204; bus.status_in = 5'b10101;
    cyc("idle_fetch", 1'b1, mk(1, 0, 0, 0, 0, 0));
    bus.instr_valid = 1'b1; bus.instr_in = I1;
    cyc("accept1", 1'b1, mk(1, 0, 0, PCINC, 0, 0));
    bus.instr_valid = 1'b0; bus.instr_in = '0;
    cyc("exec1", 1'b1, mk(0, I1, 0, 33'h1_0000_0204, 0, 0));
    cyc("back_fetch", 1'b1, mk(1, I1, 0, 0, 5'h15, 0));

    // Stall blocks fetch accept
    bus.instr_valid = 1'b1; bus.instr_in = I2; bus.stall = 1'b1;
    cyc("fetch_stall", 1'b1, mk(1, I1, 0, 0, 5'h15, 0));
    bus.stall = 1'b0;
    cyc("accept2", 1'b1, mk(1, I1, 0, PCINC, 5'h15, 0));

    // Multi-step with a 3-cycle stall in step 1
    bus.instr_valid = 1'b0; bus.cw_in = 33'h0_0000_0201; bus.status_in = 5'b00011;
    cyc("ms_step0", 1'b1, mk(0, I2, 0, 33'h0_0000_0201, 5'h15, 0));
    bus.cw_in = 33'h1_0000_02C6; bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc("stall_step1", 1'b1, mk(0, I2, 1, 33'h1_0000_0002, 5'h15, 0));
    end
    bus.stall = 1'b0;
    cyc("resume_step1", 1'b1, mk(0, I2, 1, 33'h1_0000_02C6, 5'h15, 0));
    bus.cw_in = 33'h0_8000_0000;
    cyc("ms_step2", 1'b1, mk(0, I2, 2, 33'h0_8000_0000, 5'h03, 0));
    cyc("ms_done", 1'b1, mk(1, I2, 2, 0, 5'h03, 0));

    // Reset in EXEC step 2 with rf_w set
    bus.instr_valid = 1'b1; bus.instr_in = I3;
    cyc("accept3", 1'b1, mk(1, I2, 2, PCINC, 5'h03, 0));
    bus.instr_valid = 1'b0; bus.cw_in = 33'h0_0000_0202;
    cyc("rst_step0", 1'b1, mk(0, I3, 0, 33'h0_0000_0202, 5'h03, 0));
    bus.cw_in = 33'h0_0000_0200; reset = 1'b1;
    cyc("rst_mid", 1'b1, mk(0, I3, 2, 0, 5'h03, 0));
    reset = 1'b0;
    cyc("rst_after", 1'b1, mk(1, 0, 0, 0, 0, 0));

    // Self-loop guard: step 3 naming itself four times
    bus.instr_valid = 1'b1; bus.instr_in = I4;
    cyc("accept4", 1'b1, mk(1, 0, 0, PCINC, 0, 0));
    bus.instr_valid = 1'b0; bus.cw_in = 33'h0_0000_0003;
    cyc("loop_step0", 1'b1, mk(0, I4, 0, 33'h0_0000_0003, 0, 0));
    for (int i = 0; i < 4; i++) begin
      cyc("loop_self", 1'b1, mk(0, I4, 3, 33'h0_0000_0003, 0, 0));
    end
    bus.instr_valid = 1'b1; bus.instr_in = I2;
    cyc("loop_halt", 1'b1, mk(0, I4, 3, 0, 0, 1));
    cyc("halt_hold", 1'b1, mk(0, I4, 3, 0, 0, 1));

    // Zero instruction halts; later fetches ignored
    reset = 1'b1;
    cyc("", 1'b0, '0);
    reset = 1'b0; bus.instr_in = '0;
    cyc("accept_zero", 1'b1, mk(1, 0, 0, PCINC, 0, 0));
    bus.instr_in = I2;
    cyc("halt_zero", 1'b1, mk(0, 0, 0, 0, 0, 1));
    bus.stall = 1'b1;
    cyc("halt_ignore", 1'b1, mk(0, 0, 0, 0, 0, 1));
    bus.stall = 1'b0;
    cyc("", 1'b0, '0);

    n_checks++;
    if (q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations unconsumed, want 0", q_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
